sdpb_buf_reader: RTL and testbench
==================================

SDPB_BUF_READER -- requirements
Module: sdpb_buf_reader

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; all logic on the clk rising edge.
REQ-002 Ports, clock and reset first (name  dir  width  meaning):
- clk  in  1  single clock, shared with the buffer writer and both SDPB ports
- reset  in  1  synchronous, active-high
- enable  in  1  playback enable
- start_level  in  13  fill, in words, required before playback starts
- wr_ptr  in  13  writer pointer: 12-bit address plus wrap bit
- rd_ptr  out  13  reader pointer, returned to the writer for full detection
- fill  out  13  words buffered, wr_ptr - rd_ptr mod 2^13
- ram_ceb  out  1  SDPB read clock enable
- ram_oce  out  1  SDPB output enable, constant 1
- ram_adb  out  12  SDPB read address
- ram_dout  in  16  SDPB read data, valid 1 cycle after ram_ceb
- m_data  out  16  output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- underrun  out  1  one-cycle pulse on underrun
- underrun_sticky  out  1  underrun seen since the last time enable was low
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL implement the states IDLE, PRIME and RUN.
REQ-004 IDLE: each cycle rd_ptr <= wr_ptr, issue no reads, hold m_valid=0; go to PRIME when enable=1.
REQ-005 PRIME: go to RUN when fill >= max(start_level, 1); issue no reads.
REQ-006 RUN: issue a read (ram_ceb=1, ram_adb=rd_ptr[11:0], rd_ptr++) when fill != 0 and skid occupancy + in-flight reads < 2.
REQ-007 rd_ptr SHALL wrap from 0x1FFF to 0x0000, so the address wraps 4095 -> 0 and the wrap bit toggles.
REQ-008 Read latency SHALL be 1 cycle: ram_dout is pushed into the 2-entry skid in the cycle after issue.
REQ-009 Output handshake SHALL be valid/ready:
- m_data is held stable while m_valid=1 and m_ready=0
- a transfer occurs when m_valid & m_ready
- m_valid/m_data are driven from the skid head
REQ-010 Throughput SHALL be 1 word/cycle when fill > 0 and m_ready is held high; first m_valid comes 2 cycles after entering RUN.
REQ-011 Underrun SHALL be detected in RUN when m_ready=1, m_valid=0, fill=0 and no read is in flight:
- pulse underrun
- set underrun_sticky
- go to PRIME
REQ-012 A skid push and pop in the same cycle SHALL keep occupancy unchanged; the skid never overflows.
REQ-013 enable=0 in any state SHALL cause, next cycle:
- state IDLE
- skid flushed, m_valid=0
- any in-flight read discarded
- underrun_sticky cleared
REQ-014 fill > 4096 is illegal input; behaviour is unspecified, and the writer guarantees it never happens.
REQ-015 An output register SHALL NOT change value while its update condition is false.

Reset
REQ-016 On reset, next cycle:
- state=IDLE; rd_ptr=0
- skid empty; m_valid=0, m_data=0
- ram_ceb=0, ram_adb=0
- underrun=0, underrun_sticky=0, busy=0
- ram_oce stays 1
REQ-017 Reset SHALL override enable and all other inputs.

Structure
REQ-018 Package sdpb_pkg SHALL hold ADDR_W=12, PTR_W=13, DATA_W=16 and the state enum; the writer side shares it.
REQ-019 The 2-entry skid buffer SHALL be the sub-module sdpb_rd_skid (push, data, pop, occupancy, head).
REQ-020 The bench SHALL use a behavioural SDPB model with 1-cycle bypass read latency.

Verification
REQ-021 Prime: start_level=8, writer fills 1 word/cycle, m_ready=1 -> RUN when fill=8; m_data reproduces writer data 0,1,2,... in order with no gaps.
REQ-022 Backpressure: m_ready toggled randomly, 1000 words -> no loss, no duplication, m_data stable while stalled.
REQ-023 Wrap: rd_ptr starting at 0x1FFC, 8 reads -> ram_adb sequence 4092,4093,4094,4095,0,1,2,3 and rd_ptr ends at 0x0004.
REQ-024 Underrun: writer stops, m_ready=1 -> one underrun pulse, underrun_sticky=1, state PRIME; resumes only after fill >= start_level.
REQ-025 Disable mid-stream: enable=0 with skid full and a read in flight -> next cycle m_valid=0, rd_ptr=wr_ptr, underrun_sticky=0, busy=0.
REQ-026 Reset mid-RUN: reset pulsed -> all outputs match REQ-016 next cycle.

Source files
------------

// File: rtl/sdpb_pkg.sv
// sdpb_pkg: widths and reader state encoding shared by the SDPB buffer writer and reader
package sdpb_pkg;
    localparam int ADDR_W = 12;
    localparam int PTR_W  = 13;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;
endpackage

// File: rtl/sdpb_rd_skid.sv
// sdpb_rd_skid: 2-entry skid absorbing SDPB read data ahead of the valid/ready output
module sdpb_rd_skid
    import sdpb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] tail;
    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop && push) head <= (occ == 2'd2) ? tail : data;
            else if (pop) head <= tail;
            else if (push && occ == 2'd0) head <= data;
            // tail only receives data when the head slot stays occupied
            if (push && (pop ? occ == 2'd2 : occ != 2'd0)) tail <= data;
        end
    end
endmodule

// File: rtl/sdpb_buf_reader.sv
// sdpb_buf_reader: primes from a circular SDPB buffer, then streams words out over valid/ready
module sdpb_buf_reader
    import sdpb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [PTR_W-1:0]  start_level,
    input  logic [PTR_W-1:0]  wr_ptr,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic [PTR_W-1:0]  fill,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              underrun,
    output logic              underrun_sticky,
    output logic              busy
);
    state_t state, state_nx;
    logic inflight, pop, rd_en, urun;
    logic [1:0] occ;
    logic [PTR_W-1:0] thresh;
    assign fill    = wr_ptr - rd_ptr;
    assign thresh  = (start_level == '0) ? PTR_W'(1) : start_level;
    assign m_valid = occ != 2'd0;
    assign pop     = m_valid & m_ready;
    assign busy    = state != ST_IDLE;
    assign ram_oce = 1'b1;
    assign ram_ceb = rd_en;
    assign ram_adb = rd_ptr[ADDR_W-1:0];
    // counting this cycle's pop lets a read issue every cycle without overflowing the skid
    always_comb begin
        rd_en    = enable && state == ST_RUN && fill != '0 &&
                   ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
        urun     = enable && state == ST_RUN && m_ready && !m_valid && fill == '0 && !inflight;
        state_nx = state;
        if (!enable) state_nx = ST_IDLE;
        else if (state == ST_IDLE) state_nx = ST_PRIME;
        else if (state == ST_PRIME && fill >= thresh) state_nx = ST_RUN;
        else if (urun) state_nx = ST_PRIME;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            rd_ptr          <= '0;
            inflight        <= 1'b0;
            underrun        <= 1'b0;
            underrun_sticky <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= rd_en;
            underrun <= urun;
            if (!enable) underrun_sticky <= 1'b0;
            else if (urun) underrun_sticky <= 1'b1;
            if (!enable || state == ST_IDLE) rd_ptr <= wr_ptr;
            else if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    sdpb_rd_skid u_skid (
        .clk   (clk),
        .reset (reset),
        .flush (!enable),
        .push  (inflight),
        .data  (ram_dout),
        .pop   (pop),
        .occ   (occ),
        .head  (m_data)
    );
endmodule

// File: tb/tb_sdpb_buf_reader.sv
// tb_sdpb_buf_reader: writer + SDPB model drive the reader; a negedge monitor scores every transfer
module tb_sdpb_buf_reader;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, m_ready = 1'b0;
    logic [12:0] start_level = 13'd8, wr_ptr = '0, rd_ptr, fill;
    logic ram_ceb, ram_oce, m_valid, underrun, underrun_sticky, busy;
    logic [11:0] ram_adb;
    logic [15:0] ram_dout = '0, m_data, wdata = '0, prev_data;
    logic [15:0] mem [0:4095];
    logic [15:0] sb [$];
    logic wr_en = 1'b0, prev_stall = 1'b0;
    int checks = 0, fails = 0, xfers = 0;

    always #5 clk = ~clk;

    sdpb_buf_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .start_level(start_level),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .fill(fill), .ram_ceb(ram_ceb),
        .ram_oce(ram_oce), .ram_adb(ram_adb), .ram_dout(ram_dout), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .underrun(underrun),
        .underrun_sticky(underrun_sticky), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // writer and SDPB model: sample requests before the edge, apply them just after it
    task automatic tick;
        logic ce, we;
        logic [11:0] a;
        @(negedge clk);
        ce = ram_ceb;
        a  = ram_adb;
        we = wr_en;
        @(posedge clk);
        #1;
        if (we) begin
            mem[wr_ptr[11:0]] = wdata;
            sb.push_back(wdata);
            wr_ptr = wr_ptr + 1'b1;
            wdata  = wdata + 1'b1;
        end
        if (ce) ram_dout = mem[a];
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && enable) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL xfer_unexpected actual=%0d expected=none", m_data);
                end else chk("xfer_data", 32'(m_data), 32'(sb.pop_front()));
                xfers++;
            end
        end
        prev_stall = !reset && enable && m_valid && !m_ready;
        prev_data  = m_data;
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_rd_ptr"}, 32'(rd_ptr), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_ram_ceb"}, 32'(ram_ceb), 32'd0);
        chk({tag, "_ram_adb"}, 32'(ram_adb), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_sticky"}, 32'(underrun_sticky), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
    endtask

    initial begin
        int n, pf, cnt, x0;
        logic [11:0] adb [8];
        logic [11:0] exp_adb [8];
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        tick;
        tick;
        check_reset_state("init");
        reset = 1'b0;
        // prime: 8 words needed, then a gapless stream
        enable = 1'b1; wr_en = 1'b1; m_ready = 1'b1;
        n = 0; pf = 0;
        while (!ram_ceb && n < 50) begin
            pf = int'(fill);
            tick;
            n++;
        end
        chk("prime_cycles", 32'(n), 32'd9);
        chk("prime_fill", 32'(pf), 32'd8);
        tick;
        chk("first_valid_early", 32'(m_valid), 32'd0);
        tick;
        chk("first_valid", 32'(m_valid), 32'd1);
        chk("first_data", 32'(m_data), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (!m_valid) cnt++;
        end
        chk("stream_gaps", 32'(cnt), 32'd0);
        // underrun: writer stops with m_ready high
        wr_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (underrun) cnt++;
        end
        chk("underrun_pulses", 32'(cnt), 32'd1);
        chk("underrun_sticky", 32'(underrun_sticky), 32'd1);
        chk("underrun_busy", 32'(busy), 32'd1);
        chk("underrun_drained", 32'(sb.size()), 32'd0);
        wr_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) wr_en = 1'b0;
            tick;
            if (ram_ceb || m_valid) cnt++;
        end
        chk("reprime_hold", 32'(cnt), 32'd0);
        chk("reprime_fill", 32'(fill), 32'd7);
        wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        n = 0;
        while (!ram_ceb && n < 10) begin tick; n++; end
        chk("reprime_resume", 32'(ram_ceb), 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin tick; n++; end
        for (int i = 0; i < 5; i++) tick;
        chk("reprime_drained", 32'(sb.size()), 32'd0);
        // backpressure: 1000 words with random m_ready
        x0 = xfers;
        wr_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick;
        end
        wr_en = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        chk("bp_left", 32'(sb.size()), 32'd0);
        chk("bp_count", 32'(xfers - x0), 32'd1000);
        // disable mid-stream
        m_ready = 1'b1;
        wr_en = 1'b1;
        n = 0;
        while (!m_valid && n < 40) begin tick; n++; end
        tick;
        tick;
        chk("dis_pre_valid", 32'(m_valid), 32'd1);
        chk("dis_pre_sticky", 32'(underrun_sticky), 32'd1);
        enable = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        tick;
        chk("dis_valid", 32'(m_valid), 32'd0);
        chk("dis_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));
        chk("dis_sticky", 32'(underrun_sticky), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (m_valid || ram_ceb) cnt++;
        end
        chk("dis_quiet", 32'(cnt), 32'd0);
        // wrap: pointer starts at 0x1FFC
        wr_ptr = 13'h1FFC;
        tick;
        tick;
        chk("wrap_rd_start", 32'(rd_ptr), 32'h1FFC);
        exp_adb = '{12'd4092, 12'd4093, 12'd4094, 12'd4095, 12'd0, 12'd1, 12'd2, 12'd3};
        enable = 1'b1;
        wr_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 8) wr_en = 1'b0;
            if (ram_ceb) begin
                if (cnt < 8) adb[cnt] = ram_adb;
                cnt++;
            end
            tick;
        end
        chk("wrap_reads", 32'(cnt), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("wrap_adb%0d", i), 32'(adb[i]), 32'(exp_adb[i]));
        chk("wrap_rd_end", 32'(rd_ptr), 32'h0004);
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        // reset mid-RUN
        chk("rst_pre_sticky", 32'(underrun_sticky), 32'd1);
        wr_en = 1'b1;
        n = 0;
        while (!m_valid && n < 40) begin tick; n++; end
        tick;
        tick;
        chk("rst_pre_valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        wr_en = 1'b0;
        sb.delete();
        tick;
        check_reset_state("midrun");
        reset = 1'b0;
        enable = 1'b0;
        tick;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
